// File: rtl/tracker_pkg.sv
// Shared constants and types for the glove-tracking path: the pixel scanner
// and the per-region color trackers agree on frame geometry and region codes.
package tracker_pkg;

  localparam int DEFAULT_WIDTH  = 640;
  localparam int DEFAULT_HEIGHT = 480;
  localparam int REGION_WIDTH   = DEFAULT_WIDTH / 4;

  localparam logic [7:0] DEFAULT_G_MIN  = 8'd100;
  localparam logic [7:0] DEFAULT_MARGIN = 8'd40;

  typedef enum logic [1:0] {
    REG_RED    = 2'd0,
    REG_GREEN  = 2'd1,
    REG_YELLOW = 2'd2,
    REG_BLUE   = 2'd3
  } region_t;

  // Contents of the first pipeline stage: raw color plus resolved raster
  // position and a flag marking the last pixel of a complete frame.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [9:0] x;
    logic [9:0] y;
    logic       last;
  } stage1_t;

  // Window edge for a region index; idx may be 4 to produce the upper edge
  // of the blue region.
  function automatic logic [9:0] region_bound(input logic [2:0] idx,
                                              input int region_width);
    return 10'(int'(idx) * region_width);
  endfunction

endpackage

// File: rtl/green_classifier.sv
// Second pipeline stage of the scanner: registered "is this pixel green"
// decision. All sums are 9 bits wide so R/B + MARGIN never wraps.
module green_classifier
  import tracker_pkg::*;
#(
  parameter logic [7:0] G_MIN  = DEFAULT_G_MIN,
  parameter logic [7:0] MARGIN = DEFAULT_MARGIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  output logic       green
);

  logic [7:0] others [2];
  logic [1:0] margin_ok;
  logic       level_ok;

  assign others[0] = r;
  assign others[1] = b;

  // G must dominate each of R and B by at least MARGIN.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_margin
      assign margin_ok[gi] = ({1'b0, g} >= ({1'b0, others[gi]} + {1'b0, MARGIN}));
    end
  endgenerate

  assign level_ok = (g >= G_MIN);

  // Register the decision; an invalid slot always reads as not green.
  always_ff @(posedge clk) begin
    if (reset) begin
      green <= 1'b0;
    end else begin
      green <= valid & level_ok & (&margin_ok);
    end
  end

endmodule

// File: rtl/green_pixel_scanner.sv
// Producer side of the tracker interface: tracks raster position, checks
// frame alignment, classifies pixels green and emits them two cycles later
// together with combinational region window bounds.
module green_pixel_scanner
  import tracker_pkg::*;
#(
  parameter int         WIDTH  = DEFAULT_WIDTH,
  parameter int         HEIGHT = DEFAULT_HEIGHT,
  parameter logic [7:0] G_MIN  = DEFAULT_G_MIN,
  parameter logic [7:0] MARGIN = DEFAULT_MARGIN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_valid,
  input  logic       frame_sync,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  input  logic [1:0] region,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       eh_verde,
  output logic       out_valid,
  output logic [9:0] reg_min,
  output logic [9:0] reg_max,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       sync_err
);

  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);
  // WIDTH is outside every open region window, so idle slots are invisible
  // to the downstream trackers.
  localparam logic [9:0] X_IDLE = 10'(WIDTH);
  localparam int         REG_W  = WIDTH / 4;

  logic [9:0] cx;
  logic [9:0] cy;
  logic [9:0] cx_next;
  logic [9:0] cy_next;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_last;
  logic       at_origin;

  stage1_t    s1;
  logic       s1_valid;

  // Resolve the position of the incoming pixel; a sync always wins and
  // places it at the origin, even on the last position of a frame.
  always_comb begin
    at_origin = (cx == 10'd0) && (cy == 10'd0);
    pix_x     = frame_sync ? 10'd0 : cx;
    pix_y     = frame_sync ? 10'd0 : cy;
    pix_last  = (pix_x == X_LAST) && (pix_y == Y_LAST);
    cx_next   = pix_x + 10'd1;
    cy_next   = pix_y;
    if (pix_x == X_LAST) begin
      cx_next = 10'd0;
      cy_next = (pix_y == Y_LAST) ? 10'd0 : pix_y + 10'd1;
    end
  end

  // Raster counters and sticky misalignment flag advance only on valid pixels.
  always_ff @(posedge clk) begin
    if (reset) begin
      cx       <= 10'd0;
      cy       <= 10'd0;
      sync_err <= 1'b0;
    end else if (pix_valid) begin
      cx <= cx_next;
      cy <= cy_next;
      if (frame_sync && !at_origin) begin
        sync_err <= 1'b1;
      end
    end
  end

  // Stage 1: capture color, resolved position and last-pixel flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      s1_valid <= pix_valid;
      if (pix_valid) begin
        s1.r    <= R;
        s1.g    <= G;
        s1.b    <= B;
        s1.x    <= pix_x;
        s1.y    <= pix_y;
        s1.last <= pix_last;
      end
    end
  end

  // Stage 2 color decision runs alongside the position/statistics registers.
  green_classifier #(
    .G_MIN  (G_MIN),
    .MARGIN (MARGIN)
  ) u_classifier (
    .clk   (clk),
    .reset (reset),
    .valid (s1_valid),
    .r     (s1.r),
    .g     (s1.g),
    .b     (s1.b),
    .green (eh_verde)
  );

  // Stage 2: drive the pixel stream; y holds across bubbles, x goes idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= X_IDLE;
      y           <= 10'd0;
      out_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      out_valid  <= s1_valid;
      frame_done <= s1_valid & s1.last;
      if (s1_valid) begin
        x <= s1.x;
        y <= s1.y;
        if (s1.last) begin
          frame_count <= frame_count + 8'd1;
        end
      end else begin
        x <= X_IDLE;
      end
    end
  end

  // Region windows are a pure function of the current select.
  always_comb begin
    reg_min = region_bound({1'b0, region}, REG_W);
    reg_max = region_bound({1'b0, region} + 3'd1, REG_W);
  end

endmodule

// File: tb/tb_green_pixel_scanner.sv
// Scoreboard bench for green_pixel_scanner: the driver predicts each pixel's
// position/classification from a reference raster model, the monitor pops
// and compares whenever the design emits a pixel.
module tb_green_pixel_scanner;

  localparam int W = 640;
  localparam int H = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] R = 8'd0;
  logic [7:0] G = 8'd0;
  logic [7:0] B = 8'd0;
  logic [1:0] region = 2'd0;
  logic [9:0] x;
  logic [9:0] y;
  logic       eh_verde;
  logic       out_valid;
  logic [9:0] reg_min;
  logic [9:0] reg_max;
  logic       frame_done;
  logic [7:0] frame_count;
  logic       sync_err;

  green_pixel_scanner #(
    .WIDTH  (W),
    .HEIGHT (H),
    .G_MIN  (8'd100),
    .MARGIN (8'd40)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .frame_sync  (frame_sync),
    .R           (R),
    .G           (G),
    .B           (B),
    .region      (region),
    .x           (x),
    .y           (y),
    .eh_verde    (eh_verde),
    .out_valid   (out_valid),
    .reg_min     (reg_min),
    .reg_max     (reg_max),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit green;
    bit last;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   show = 1'b0;
  int   m_cx = 0;
  int   m_cy = 0;
  int   mon_frames = 0;
  int   done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Monitor: compare emitted pixels against the scoreboard, idle slots
  // against the idle encoding. In-flight pixels are dropped on reset.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (frame_done) done_seen++;
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("x", int'(x), e.x);
          check("y", int'(y), e.y);
          check("eh_verde", int'(eh_verde), int'(e.green));
          check("frame_done", int'(frame_done), int'(e.last));
          check("latency", cyc - e.cyc, 2);
          if (e.last) begin
            mon_frames++;
            check("frame_count", int'(frame_count), mon_frames % 256);
          end
          if (show)
            $display("pix x=%0d y=%0d green=%0d done=%0d", x, y, eh_verde, frame_done);
        end
      end else begin
        check("idle_x", int'(x), W);
        check("idle_green", int'(eh_verde), 0);
        check("idle_done", int'(frame_done), 0);
      end
      if (reset) begin
        q.delete();
        mon_frames = 0;
        done_seen  = 0;
      end
    end
  end

  // Drive one slot; for a valid pixel push what the design must emit.
  task automatic drive(input bit v, input bit s, input int r, input int g, input int b);
    exp_t e;
    int nx;
    int ny;
    pix_valid  = v;
    frame_sync = s;
    R = 8'(r);
    G = 8'(g);
    B = 8'(b);
    if (v) begin
      e.x = s ? 0 : m_cx;
      e.y = s ? 0 : m_cy;
      e.last  = (e.x == W - 1) && (e.y == H - 1);
      e.green = (g >= 100) && (g >= r + 40) && (g >= b + 40);
      e.cyc   = cyc;
      q.push_back(e);
      nx = e.x + 1;
      ny = e.y;
      if (nx == W) begin
        nx = 0;
        ny = (ny + 1 == H) ? 0 : ny + 1;
      end
      m_cx = nx;
      m_cy = ny;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_drive(input bit s);
    int r;
    int g;
    int b;
    g = int'($urandom_range(0, 255));
    if ($urandom_range(0, 1) == 1) begin
      r = int'($urandom_range(0, 80));
      b = int'($urandom_range(0, 80));
    end else begin
      r = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
    end
    drive(1'b1, s, r, g, b);
  endtask

  task automatic stream_to(input int tx, input int ty, input int maxn);
    int n;
    n = 0;
    while (!(m_cx == tx && m_cy == ty) && n < maxn) begin
      if ($urandom_range(0, 15) == 0) drive(1'b0, 1'b0, 0, 0, 0);
      else rand_drive(1'b0);
      n++;
    end
  endtask

  task automatic drain();
    repeat (4) drive(1'b0, 1'b0, 0, 0, 0);
    check("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    pix_valid  = 1'b0;
    frame_sync = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_cx  = 0;
    m_cy  = 0;
  endtask

  initial begin
    do_reset();
    mon_en = 1'b1;
    show   = 1'b1;

    check("rst_x", int'(x), W);
    check("rst_y", int'(y), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_eh_verde", int'(eh_verde), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_count", int'(frame_count), 0);
    check("rst_sync_err", int'(sync_err), 0);

    // First pixels after reset start at the origin without a sync.
    drive(1'b1, 1'b0, 200, 50, 40);
    drive(1'b1, 1'b0, 90, 150, 80);
    drive(1'b1, 1'b0, 10, 120, 90);
    drain();

    // Threshold and margin boundaries, including the no-wrap case.
    drive(1'b1, 1'b0, 60, 100, 60);
    drive(1'b1, 1'b0, 60, 99, 60);
    drive(1'b1, 1'b0, 255, 255, 0);
    drive(1'b1, 1'b0, 61, 100, 60);
    drive(1'b1, 1'b0, 60, 100, 61);
    drive(1'b1, 1'b0, 0, 255, 215);
    drain();

    // Bubbles keep position.
    do_reset();
    drive(1'b1, 1'b0, 0, 200, 0);
    drive(1'b0, 1'b0, 0, 0, 0);
    drive(1'b0, 1'b0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 200, 0);
    drain();

    for (int r = 0; r < 4; r++) begin
      region = 2'(r);
      #1;
      check("reg_min", int'(reg_min), r * (W / 4));
      check("reg_max", int'(reg_max), (r + 1) * (W / 4));
    end

    // Reset mid-line drops in-flight pixels and restarts at the origin.
    do_reset();
    repeat (5) rand_drive(1'b0);
    do_reset();
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_x", int'(x), W);
    check("mid_rst_frame_count", int'(frame_count), 0);
    drive(1'b1, 1'b0, 30, 180, 20);
    drain();

    // Full frame with sync on the first pixel.
    show = 1'b0;
    do_reset();
    rand_drive(1'b1);
    stream_to(0, 0, 2 * W * H);
    drain();
    check("frame1_count", int'(frame_count), 1);
    check("frame1_done_pulses", done_seen, 1);
    check("frame1_sync_err", int'(sync_err), 0);

    // Misaligned sync mid-frame.
    stream_to(100, 10, 2 * W * H);
    rand_drive(1'b1);
    repeat (5) rand_drive(1'b0);
    drain();
    check("inject_sync_err", int'(sync_err), 1);
    check("inject_frame_count", int'(frame_count), 1);

    // Sync on the last position: sync wins, no frame completion.
    stream_to(W - 1, H - 1, 2 * W * H);
    rand_drive(1'b1);
    drain();
    check("lastsync_frame_count", int'(frame_count), 1);
    check("lastsync_done_pulses", done_seen, 1);
    check("lastsync_sync_err", int'(sync_err), 1);

    // A clean frame afterwards still counts.
    stream_to(0, 0, 2 * W * H);
    drain();
    check("frame2_count", int'(frame_count), 2);
    check("frame2_done_pulses", done_seen, 2);
    check("sticky_sync_err", int'(sync_err), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
